// File: rtl/regfile_pkg.sv
// Shared register-file definitions: bus widths, register count and the
// reset/enable encodings used by the core pipeline.
package regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegNumLog2 = 5;
    localparam int RegAddrBus = RegNumLog2;
    localparam int RegNum     = 32;

    localparam logic [RegBus-1:0]     ZeroWord    = '0;
    localparam logic                  RstEnable   = 1'b0;
    localparam logic                  WriteEnable = 1'b1;
    localparam logic                  ReadEnable  = 1'b1;
    localparam logic [RegAddrBus-1:0] NOPRegAddr  = 5'b00000;

endpackage

// File: rtl/regfile.sv
// 32 x 32-bit general-purpose register file: one synchronous write port
// (write-back) and two combinational read ports (decode operands).
// Register 0 is hard zero. Define REGFILE_BYPASS_EN to forward a same-cycle
// write-back value to a matching read port.
module regfile
    import regfile_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  we,
    input  logic [RegAddrBus-1:0] waddr,
    input  logic [RegBus-1:0]     wdata,
    input  logic                  re1,
    input  logic [RegAddrBus-1:0] raddr1,
    output logic [RegBus-1:0]     rdata1,
    input  logic                  re2,
    input  logic [RegAddrBus-1:0] raddr2,
    output logic [RegBus-1:0]     rdata2
);

    logic [RegNum-1:0][RegBus-1:0]     mem;
    logic [1:0]                        re_a;
    logic [1:0][RegAddrBus-1:0]        ra_a;
    logic [1:0][RegBus-1:0]            rd_a;

    assign re_a   = {re2, re1};
    assign ra_a   = {raddr2, raddr1};
    assign rdata1 = rd_a[0];
    assign rdata2 = rd_a[1];

    // Storage: async clear, write-back updates any register except r0.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (Rst_n == RstEnable) begin
            mem <= '0;
        end else if (we == WriteEnable && waddr != NOPRegAddr) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: identical priority chain per port (reset, r0, enable,
    // optional bypass, stored value).
    always_comb begin
        rd_a = '0;
        for (int p = 0; p < 2; p++) begin
            if (Rst_n == RstEnable) begin
                rd_a[p] = ZeroWord;
            end else if (ra_a[p] == NOPRegAddr) begin
                rd_a[p] = ZeroWord;
            end else if (re_a[p] != ReadEnable) begin
                rd_a[p] = ZeroWord;
`ifdef REGFILE_BYPASS_EN
            end else if (we == WriteEnable && waddr == ra_a[p]) begin
                // waddr != 0 is implied: ra_a[p] is already known non-zero.
                rd_a[p] = wdata;
`endif
            end else begin
                rd_a[p] = mem[ra_a[p]];
            end
        end
    end

endmodule
